// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 one-hot decoder.
package dec_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StGap  = 2'd2
    } dec_state_t;

    function automatic logic [OUT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        return OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry FIFO with asynchronous reset and a synchronous clear.
module dec_fifo2 #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] din_i,
    input  logic             pop_i,
    output logic [Width-1:0] dout_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/dec3x8_seq.sv
// Sequenced one-hot decoder: queues codes and presents each as a held, spaced pattern.
module dec3x8_seq
    import dec_pkg::*;
#(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic [OUT_W-1:0]  out_onehot,
    output logic              out_valid,
    output logic              busy
);

    dec_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  oh_q, oh_d;
    logic              ov_q, ov_d;
    logic              pop;
    logic [CODE_W-1:0] head;
    logic [1:0]        count;
    logic              full, empty;

    dec_fifo2 #(
        .Width (CODE_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (flush),
        .push_i  (in_valid && in_ready),
        .din_i   (in_code),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign in_ready   = !full;
    assign busy       = (state_q != StIdle) || (count != 2'd0);
    assign out_onehot = oh_q;
    assign out_valid  = ov_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oh_d    = oh_q;
        ov_d    = ov_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            oh_d    = '0;
            ov_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        oh_d    = code_to_onehot(head);
                        ov_d    = 1'b1;
                        cnt_d   = CNT_W'(HOLD - 1);
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (GAP > 0) begin
                        oh_d    = '0;
                        ov_d    = 1'b0;
                        cnt_d   = CNT_W'(GAP - 1);
                        state_d = StGap;
                    end else if (!empty) begin
                        // Zero-gap back-to-back: reload without an idle cycle.
                        pop   = 1'b1;
                        oh_d  = code_to_onehot(head);
                        ov_d  = 1'b1;
                        cnt_d = CNT_W'(HOLD - 1);
                    end else begin
                        oh_d    = '0;
                        ov_d    = 1'b0;
                        state_d = StIdle;
                    end
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        oh_d    = code_to_onehot(head);
                        ov_d    = 1'b1;
                        cnt_d   = CNT_W'(HOLD - 1);
                        state_d = StHold;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    oh_d    = '0;
                    ov_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            oh_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oh_q    <= oh_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_dec3x8_seq.sv
// Directed bench for dec3x8_seq across three HOLD/GAP configurations sharing one stimulus bus.
module tb_dec3x8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;

    logic [7:0] oh_a, oh_b, oh_c;
    logic       ov_a, ov_b, ov_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dec3x8_seq #(.HOLD(4), .GAP(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_code(in_code), .out_onehot(oh_a), .out_valid(ov_a), .busy(busy_a)
    );
    dec3x8_seq #(.HOLD(4), .GAP(0)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_code(in_code), .out_onehot(oh_b), .out_valid(ov_b), .busy(busy_b)
    );
    dec3x8_seq #(.HOLD(1), .GAP(0)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_code(in_code), .out_onehot(oh_c), .out_valid(ov_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // out_valid must track a non-zero pattern on every DUT at all times.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ov_a_vs_oh", {7'd0, ov_a}, {7'd0, oh_a != 8'h00});
            chk("ov_b_vs_oh", {7'd0, ov_b}, {7'd0, oh_b != 8'h00});
            chk("ov_c_vs_oh", {7'd0, ov_c}, {7'd0, oh_c != 8'h00});
        end
    end

    logic [7:0] burst_exp [14];
    logic [7:0] gap0_exp  [8];

    initial begin
        burst_exp = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80,
                      8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
        gap0_exp  = '{8'h04, 8'h04, 8'h04, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};

        // Asynchronous reset in the middle of a hold.
        do_reset();
        chk("idle_rdy", {7'd0, rdy_a}, 8'h01);
        chk("idle_busy", {7'd0, busy_a}, 8'h00);
        in_valid = 1'b1; in_code = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        chk("rst_pre_oh", oh_a, 8'h08);
        step();
        #3 rst = 1'b1;
        #1;
        chk("rst_oh", oh_a, 8'h00);
        chk("rst_ov", {7'd0, ov_a}, 8'h00);
        chk("rst_busy", {7'd0, busy_a}, 8'h00);
        chk("rst_rdy", {7'd0, rdy_a}, 8'h01);
        step();
        rst = 1'b0;

        // Single code 5 with HOLD=4, GAP=1.
        in_valid = 1'b1; in_code = 3'd5;
        step();
        in_valid = 1'b0;
        chk("single_latency", oh_a, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_hold", oh_a, 8'h20);
            chk("single_ov", {7'd0, ov_a}, 8'h01);
        end
        step();
        chk("single_end", oh_a, 8'h00);
        step();
        chk("single_busy", {7'd0, busy_a}, 8'h00);
        chk("single_rdy", {7'd0, rdy_a}, 8'h01);

        // Burst 0, 7, 3.
        do_reset();
        in_valid = 1'b1; in_code = 3'd0;
        step();
        chk("burst_e1", oh_a, 8'h00);
        in_code = 3'd7;
        step();
        chk("burst_e2", oh_a, 8'h01);
        in_code = 3'd3;
        step();
        in_valid = 1'b0;
        chk("burst_full", {7'd0, rdy_a}, 8'h00);
        chk("burst_e3", oh_a, 8'h01);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("burst_seq", oh_a, burst_exp[i]);
            if (i == 3) chk("burst_rdy_back", {7'd0, rdy_a}, 8'h01);
        end
        chk("burst_busy_end", {7'd0, busy_a}, 8'h00);

        // GAP=0: patterns abut with no zero cycle.
        do_reset();
        in_valid = 1'b1; in_code = 3'd2;
        step();
        in_code = 3'd6;
        step();
        in_valid = 1'b0;
        chk("gap0_first", oh_b, 8'h04);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("gap0_seq", oh_b, gap0_exp[i]);
        end

        // Flush with two codes queued during the hold of code 1.
        do_reset();
        in_valid = 1'b1; in_code = 3'd1;
        step();
        in_code = 3'd2;
        step();
        in_code = 3'd3;
        step();
        in_valid = 1'b0;
        chk("flush_pre_oh", oh_a, 8'h02);
        chk("flush_pre_rdy", {7'd0, rdy_a}, 8'h00);
        flush = 1'b1; in_valid = 1'b1; in_code = 3'd4;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_oh", oh_a, 8'h00);
        chk("flush_busy", {7'd0, busy_a}, 8'h00);
        chk("flush_rdy", {7'd0, rdy_a}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("flush_quiet", oh_a, 8'h00);
        end

        // HOLD=1, GAP=0 sweep of every code.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_code  = 3'(i);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk("sweep_oh", oh_c, 8'h01 << (i - 1));
                chk("sweep_onehot", {7'd0, $onehot(oh_c)}, 8'h01);
            end
        end
        in_valid = 1'b0;
        step();
        chk("sweep_end", oh_c, 8'h00);
        step();
        chk("sweep_busy", {7'd0, busy_c}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
